// File: rtl/wr_router_1to4.sv
// Routes one write request (addr/data/mask) to one of four targets chosen by an address field.
// Request accepted in cycle 0, target valid in cycle 1, o_done/o_err one cycle after handshake or timeout.
// o_req_ready is high only in IDLE; target valid is held until the selected target is ready or TIMEOUT expires.
module wr_router_1to4 #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_data,
    input  logic [DATA_W/8-1:0] i_req_bmask,
    output logic [3:0]          o_tgt_valid,
    input  logic [3:0]          i_tgt_ready,
    output logic [ADDR_W-1:0]   o_tgt_addr,
    output logic [DATA_W-1:0]   o_tgt_data,
    output logic [DATA_W/8-1:0] o_tgt_bmask,
    output logic                o_done,
    output logic                o_err
);

    localparam int BM_W  = DATA_W / 8;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [BM_W-1:0]     bmask_q, bmask_d;
    logic [1:0]          sel_q, sel_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // State and payload registers; reset drops target valid immediately, losing any in-flight request.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            bmask_q <= '0;
            sel_q   <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            bmask_q <= bmask_d;
            sel_q   <= sel_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: done/err are computed one cycle early so they register exactly with RESP.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        bmask_d = bmask_q;
        sel_d   = sel_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    data_d  = i_req_data;
                    bmask_d = i_req_bmask;
                    sel_d   = i_req_addr[SEL_LSB +: 2];
                    timer_d = '0;
                    if (i_req_bmask == '0) begin
                        // An empty mask writes nothing: report an error without touching any target.
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        valid_d = 4'b0001 << i_req_addr[SEL_LSB +: 2];
                    end
                end
            end
            ISSUE: begin
                // Ready is checked before the timer so a ready on the final cycle still succeeds.
                if (i_tgt_ready[sel_q]) begin
                    state_d = RESP;
                    valid_d = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    valid_d = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = '0;
            end
        endcase
    end

    assign o_req_ready = (state_q == IDLE);
    assign o_tgt_valid = valid_q;
    assign o_tgt_addr  = addr_q;
    assign o_tgt_data  = data_q;
    assign o_tgt_bmask = bmask_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_wr_router_1to4.sv
// Directed test of wr_router_1to4: routing, back-pressure, timeout, empty mask, reset, back-to-back.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Every wait is a bounded loop so the bench always reaches its summary line.
module tb_wr_router_1to4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_data;
    logic [3:0]  i_req_bmask;
    logic [3:0]  o_tgt_valid;
    logic [3:0]  i_tgt_ready;
    logic [31:0] o_tgt_addr;
    logic [31:0] o_tgt_data;
    logic [3:0]  o_tgt_bmask;
    logic        o_done;
    logic        o_err;

    int test_cnt = 0;
    int fail_cnt = 0;

    wr_router_1to4 #(
        .DATA_W(32), .ADDR_W(32), .SEL_LSB(28), .TIMEOUT(16)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr),
        .i_req_data(i_req_data),
        .i_req_bmask(i_req_bmask),
        .o_tgt_valid(o_tgt_valid),
        .i_tgt_ready(i_tgt_ready),
        .o_tgt_addr(o_tgt_addr),
        .o_tgt_data(o_tgt_data),
        .o_tgt_bmask(o_tgt_bmask),
        .o_done(o_done),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_data  = d;
        i_req_bmask = m;
    endtask

    int          acc_cyc [4];
    int          idx;
    int          dones;
    int          errs;
    int          multi_hot;
    logic [3:0]  cur_exp;
    logic        accept;
    logic [31:0] b2b_addr [4];

    initial begin
        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        i_req_data  = '0;
        i_req_bmask = '0;
        i_tgt_ready = '0;
        #1;
        check("rst_valid", o_tgt_valid, 4'h0);
        check("rst_done",  o_done, 1'b0);
        check("rst_err",   o_err, 1'b0);
        check("rst_ready", o_req_ready, 1'b1);
        check("rst_addr",  o_tgt_addr, 32'h0);
        step();
        step();
        i_reset = 1'b0;
        step();

        // Basic write to target 2 with ready tied high.
        i_tgt_ready = 4'hF;
        drive_req(32'h2000_0010, 32'hDEAD_BEEF, 4'hF);
        check("t2_c0_ready", o_req_ready, 1'b1);
        step();
        i_req_valid = 1'b0;
        check("t2_c1_valid", o_tgt_valid, 4'b0100);
        check("t2_c1_addr",  o_tgt_addr, 32'h2000_0010);
        check("t2_c1_data",  o_tgt_data, 32'hDEAD_BEEF);
        check("t2_c1_bmask", o_tgt_bmask, 4'hF);
        check("t2_c1_ready", o_req_ready, 1'b0);
        check("t2_c1_done",  o_done, 1'b0);
        step();
        check("t2_c2_done",  o_done, 1'b1);
        check("t2_c2_err",   o_err, 1'b0);
        check("t2_c2_valid", o_tgt_valid, 4'h0);
        check("t2_c2_ready", o_req_ready, 1'b0);
        step();
        check("t2_c3_ready", o_req_ready, 1'b1);
        check("t2_c3_done",  o_done, 1'b0);

        // Back-pressure on target 1; other targets pulse ready meanwhile.
        i_tgt_ready = 4'h0;
        drive_req(32'h1000_0000, 32'h1234_5678, 4'h3);
        step();
        i_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check("bp_valid", o_tgt_valid, 4'b0010);
            check("bp_data",  o_tgt_data, 32'h1234_5678);
            check("bp_done",  o_done, 1'b0);
            i_tgt_ready = (k == 6) ? 4'b0010 : ((k % 2) == 1 ? 4'b1101 : 4'b0000);
            step();
        end
        i_tgt_ready = 4'h0;
        check("bp_done_pulse", o_done, 1'b1);
        check("bp_err",        o_err, 1'b0);
        check("bp_valid_drop", o_tgt_valid, 4'h0);
        step();

        // Timeout on target 3: valid for exactly 16 cycles.
        drive_req(32'h3000_0004, 32'hCAFE_F00D, 4'hF);
        step();
        i_req_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            check("to_valid", o_tgt_valid, 4'b1000);
            check("to_done",  o_done, 1'b0);
            step();
        end
        check("to_valid_drop", o_tgt_valid, 4'h0);
        check("to_done_pulse", o_done, 1'b1);
        check("to_err",        o_err, 1'b1);
        step();
        check("to_idle_ready", o_req_ready, 1'b1);
        check("to_idle_done",  o_done, 1'b0);

        // Ready on the 16th cycle wins over the timeout.
        drive_req(32'h3000_0008, 32'h0BAD_F00D, 4'h1);
        step();
        i_req_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            check("tl_valid", o_tgt_valid, 4'b1000);
            if (k == 16) i_tgt_ready = 4'b1000;
            step();
        end
        i_tgt_ready = 4'h0;
        check("tl_done_pulse", o_done, 1'b1);
        check("tl_err",        o_err, 1'b0);
        step();

        // Empty byte mask: no target valid, error reported from RESP.
        drive_req(32'h0000_0000, 32'h5555_AAAA, 4'h0);
        step();
        i_req_valid = 1'b0;
        check("em_valid", o_tgt_valid, 4'h0);
        check("em_done",  o_done, 1'b1);
        check("em_err",   o_err, 1'b1);
        step();
        check("em_valid2", o_tgt_valid, 4'h0);
        check("em_ready",  o_req_ready, 1'b1);
        check("em_done2",  o_done, 1'b0);

        // Reset in the 3rd ISSUE cycle of a target-0 write.
        drive_req(32'h0000_0100, 32'h0F0F_0F0F, 4'hF);
        step();
        i_req_valid = 1'b0;
        step();
        step();
        check("rm_valid_pre", o_tgt_valid, 4'b0001);
        #2 i_reset = 1'b1;
        #1;
        check("rm_valid_async", o_tgt_valid, 4'h0);
        check("rm_ready_async", o_req_ready, 1'b1);
        step();
        i_reset = 1'b0;
        check("rm_done_rst", o_done, 1'b0);
        step();
        check("rm_done_after", o_done, 1'b0);
        check("rm_ready_after", o_req_ready, 1'b1);
        i_tgt_ready = 4'hF;
        drive_req(32'h0000_0200, 32'h7777_8888, 4'hC);
        step();
        i_req_valid = 1'b0;
        check("rm_next_valid", o_tgt_valid, 4'b0001);
        check("rm_next_data",  o_tgt_data, 32'h7777_8888);
        step();
        check("rm_next_done", o_done, 1'b1);
        check("rm_next_err",  o_err, 1'b0);
        step();

        // Back-to-back requests to targets 0..3 with request held high.
        b2b_addr[0] = 32'h0000_0040;
        b2b_addr[1] = 32'h1000_0040;
        b2b_addr[2] = 32'h2000_0040;
        b2b_addr[3] = 32'h3000_0040;
        idx = 0; dones = 0; errs = 0; multi_hot = 0; cur_exp = 4'h0;
        i_tgt_ready = 4'hF;
        drive_req(b2b_addr[0], 32'hA000_0000, 4'hF);
        for (int c = 0; c < 30; c++) begin
            if (o_done) begin
                dones++;
                if (o_err) errs++;
            end
            if ($countones(o_tgt_valid) > 1) multi_hot++;
            if (o_tgt_valid != 4'h0) check("b2b_onehot_target", o_tgt_valid, cur_exp);
            accept = i_req_valid && o_req_ready;
            if (accept) begin
                acc_cyc[idx] = c;
                cur_exp = 4'b0001 << idx;
            end
            step();
            if (accept) begin
                idx++;
                if (idx < 4) drive_req(b2b_addr[idx], 32'hA000_0000 + 32'(idx), 4'hF);
                else i_req_valid = 1'b0;
            end
        end
        check("b2b_accepts", idx, 4);
        check("b2b_dones", dones, 4);
        check("b2b_errs", errs, 0);
        check("b2b_multi_hot", multi_hot, 0);
        if (idx == 4) begin
            for (int i = 1; i < 4; i++) check("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 3);
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
